quad_decoder: RTL and testbench



---
 rtl/quad_pkg.sv | 63 ++++++
 rtl/quad_decoder_bit_sync.sv | 30 +++
 rtl/quad_decoder.sv | 128 ++++++++++++
 tb/tb_quad_decoder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared Gray-state encodings, transition classes and decoder phases for the quadrature decoder.
package quad_pkg;

    localparam int unsigned DEFAULT_SYNC_STAGES = 2;

    // Encoder phase pair {A,B}; forward rotation walks S00 -> S01 -> S11 -> S10.
    typedef enum logic [1:0] {
        S00 = 2'b00,
        S01 = 2'b01,
        S11 = 2'b11,
        S10 = 2'b10
    } gray_t;

    typedef enum logic [1:0] {
        TR_HOLD,
        TR_UP,
        TR_DOWN,
        TR_ILLEGAL
    } trans_t;

    typedef enum logic {
        PH_WARMUP,
        PH_RUN
    } phase_t;

    function automatic gray_t gray_next_up(input gray_t s);
        gray_t n;
        case (s)
            S00:     n = S01;
            S01:     n = S11;
            S11:     n = S10;
            default: n = S00;
        endcase
        return n;
    endfunction

    function automatic gray_t gray_next_down(input gray_t s);
        gray_t n;
        case (s)
            S00:     n = S10;
            S10:     n = S11;
            S11:     n = S01;
            default: n = S00;
        endcase
        return n;
    endfunction

    // Any change that is neither one step up nor one step down moved both phases at once.
    function automatic trans_t classify(input gray_t prev, input gray_t cur);
        trans_t t;
        if (cur == prev) begin
            t = TR_HOLD;
        end else if (cur == gray_next_up(prev)) begin
            t = TR_UP;
        end else if (cur == gray_next_down(prev)) begin
            t = TR_DOWN;
        end else begin
            t = TR_ILLEGAL;
        end
        return t;
    endfunction

endpackage

// File: rtl/quad_decoder_bit_sync.sv
// Multi-flop synchronizer bringing one asynchronous level into the clk domain.
module bit_sync
    import quad_pkg::*;
#(
    parameter int unsigned STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d_i};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/quad_decoder.sv
// Quadrature A/B decoder: synchronizes both phases, classifies each Gray transition and
// keeps a wrapping up/down position count with step/error pulses and a sticky error flag.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             step,
    output logic             dir,
    output logic             err,
    output logic             err_flag
);

    localparam int unsigned WARM_W = $clog2(SYNC_STAGES + 1);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(SYNC_STAGES);

    logic   a_s;
    logic   b_s;
    gray_t  cur;
    trans_t trans;

    phase_t            phase_q,    phase_d;
    logic [WARM_W-1:0] warm_q,     warm_d;
    gray_t             prev_q,     prev_d;
    logic [WIDTH-1:0]  count_q,    count_d;
    logic              dir_q,      dir_d;
    logic              step_q,     step_d;
    logic              err_q,      err_d;
    logic              err_flag_q, err_flag_d;

    bit_sync #(.STAGES(SYNC_STAGES)) u_sync_a (
        .clk (clk),
        .rst (rst),
        .d_i (a_in),
        .q_o (a_s)
    );

    bit_sync #(.STAGES(SYNC_STAGES)) u_sync_b (
        .clk (clk),
        .rst (rst),
        .d_i (b_in),
        .q_o (b_s)
    );

    assign cur   = gray_t'({a_s, b_s});
    assign trans = classify(prev_q, cur);

    always_comb begin
        phase_d    = phase_q;
        warm_d     = warm_q;
        prev_d     = cur;
        count_d    = count_q;
        dir_d      = dir_q;
        step_d     = 1'b0;
        err_d      = 1'b0;
        err_flag_d = err_flag_q;

        // Warm-up only tracks prev so a resting non-00 encoder is not seen as motion.
        if (phase_q == PH_WARMUP) begin
            warm_d = warm_q + 1'b1;
            if (warm_q == WARM_LAST) begin
                phase_d = PH_RUN;
            end
        end else begin
            case (trans)
                TR_UP: begin
                    count_d = count_q + 1'b1;
                    dir_d   = 1'b1;
                    step_d  = 1'b1;
                end
                TR_DOWN: begin
                    count_d = count_q - 1'b1;
                    dir_d   = 1'b0;
                    step_d  = 1'b1;
                end
                TR_ILLEGAL: begin
                    err_d      = 1'b1;
                    err_flag_d = 1'b1;
                end
                default: ;
            endcase
        end

        // Clear overrides any event decoded this cycle; prev has already absorbed it.
        if (clr) begin
            count_d    = '0;
            step_d     = 1'b0;
            err_d      = 1'b0;
            err_flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q    <= PH_WARMUP;
            warm_q     <= '0;
            prev_q     <= S00;
            count_q    <= '0;
            dir_q      <= 1'b0;
            step_q     <= 1'b0;
            err_q      <= 1'b0;
            err_flag_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            warm_q     <= warm_d;
            prev_q     <= prev_d;
            count_q    <= count_d;
            dir_q      <= dir_d;
            step_q     <= step_d;
            err_q      <= err_d;
            err_flag_q <= err_flag_d;
        end
    end

    assign count    = count_q;
    assign step     = step_q;
    assign dir      = dir_q;
    assign err      = err_q;
    assign err_flag = err_flag_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Scoreboarded random/directed bench for quad_decoder against a position-index reference model.
module tb_quad_decoder;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned SS    = 2;
    localparam int          MODV  = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             a_in = 1'b0;
    logic             b_in = 1'b0;
    logic             clr = 1'b0;
    logic [WIDTH-1:0] count;
    logic             step;
    logic             dir;
    logic             err;
    logic             err_flag;

    quad_decoder #(.WIDTH(WIDTH), .SYNC_STAGES(SS)) dut (
        .clk      (clk),
        .rst      (rst),
        .a_in     (a_in),
        .b_in     (b_in),
        .clr      (clr),
        .count    (count),
        .step     (step),
        .dir      (dir),
        .err      (err),
        .err_flag (err_flag)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_err;
        int cnt;
        bit d;
        bit flag;
        int at;
    } ev_t;

    ev_t sb[$];

    // Reference model: position on the 4-state Gray circle plus an abstract counter.
    logic [1:0] seq [4];
    int m_idx  = 0;
    int m_pos  = 0;
    bit m_dir  = 1'b0;
    bit m_flag = 1'b0;

    function automatic int idx_of(input logic [1:0] v);
        case (v)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a new phase pair without predicting any event (reset / warm-up windows).
    task automatic raw_set(input logic [1:0] v);
        {a_in, b_in} = v;
        m_idx = idx_of(v);
    endtask

    // Drive a new phase pair (called just after a negedge) and predict the decoder response.
    task automatic set_ab(input logic [1:0] v);
        int   delta;
        ev_t  e;
        {a_in, b_in} = v;
        delta = (idx_of(v) - m_idx + 4) % 4;
        m_idx = idx_of(v);
        if (delta != 0) begin
            if (delta == 1) begin
                m_pos = (m_pos + 1) % MODV;
                m_dir = 1'b1;
            end else if (delta == 3) begin
                m_pos = (m_pos + MODV - 1) % MODV;
                m_dir = 1'b0;
            end else begin
                m_flag = 1'b1;
            end
            e.is_err = (delta == 2);
            e.cnt    = m_pos;
            e.d      = m_dir;
            e.flag   = m_flag;
            e.at     = cyc + 3;
            sb.push_back(e);
        end
    endtask

    task automatic fwd(input int hold);
        set_ab(seq[(m_idx + 1) % 4]);
        wait_cycles(hold);
    endtask

    task automatic do_clr();
        wait_cycles(4);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        m_pos  = 0;
        m_flag = 1'b0;
    endtask

    task automatic model_reset();
        m_pos  = 0;
        m_dir  = 1'b0;
        m_flag = 1'b0;
        sb.delete();
    endtask

    // Monitor: every step/err pulse must match the oldest predicted event, on the predicted cycle.
    always @(negedge clk) begin
        if (rst) begin
            if (step && err) begin
                tests++;
                fails++;
                $display("FAIL step_err_overlap: step=%0b err=%0b at cycle %0d, required not both", step, err, cyc);
            end
            if (step || err) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_event: step=%0b err=%0b count=%0d at cycle %0d, required no pulse",
                             step, err, count, cyc);
                end else begin
                    ev_t e;
                    e = sb.pop_front();
                    if (err != e.is_err || step == e.is_err || int'(count) != e.cnt ||
                        dir != e.d || err_flag != e.flag || cyc != e.at) begin
                        fails++;
                        $display("FAIL event: got err=%0b step=%0b count=%0d dir=%0b flag=%0b cyc=%0d, expected err=%0b step=%0b count=%0d dir=%0b flag=%0b cyc=%0d",
                                 err, step, count, dir, err_flag, cyc,
                                 e.is_err, !e.is_err, e.cnt, e.d, e.flag, e.at);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] v;
        int         r;
        seq = '{2'b00, 2'b01, 2'b11, 2'b10};

        // Reset with both phases low
        raw_set(2'b00);
        wait_cycles(3);
        check("reset_count", int'(count), 0);
        check("reset_step", int'(step), 0);
        check("reset_dir", int'(dir), 0);
        check("reset_err", int'(err), 0);
        check("reset_err_flag", int'(err_flag), 0);
        rst = 1'b1;
        model_reset();
        wait_cycles(5);

        // Four forward steps
        for (int i = 0; i < 4; i++) fwd(4);
        wait_cycles(4);
        check("fwd4_count", int'(count), 4);
        check("fwd4_dir", int'(dir), 1);
        check("fwd4_err_flag", int'(err_flag), 0);

        // Reverse wrap 0 -> 15, forward wrap 15 -> 0
        do_clr();
        check("clr_count", int'(count), 0);
        set_ab(2'b10);
        wait_cycles(4);
        check("wrap_down_count", int'(count), 15);
        check("wrap_down_dir", int'(dir), 0);
        set_ab(2'b00);
        wait_cycles(4);
        check("wrap_up_count", int'(count), 0);
        check("wrap_up_dir", int'(dir), 1);

        // Illegal jump then clear
        set_ab(2'b11);
        wait_cycles(4);
        check("illegal_count", int'(count), 0);
        check("illegal_err_flag", int'(err_flag), 1);
        do_clr();
        check("illegal_clr_count", int'(count), 0);
        check("illegal_clr_flag", int'(err_flag), 0);

        // Encoder resting at 11 through reset release: no spurious events
        rst = 1'b0;
        raw_set(2'b11);
        wait_cycles(3);
        model_reset();
        rst = 1'b1;
        wait_cycles(10);
        check("rest11_count", int'(count), 0);
        check("rest11_err_flag", int'(err_flag), 0);

        // Count to 7, then asynchronous reset mid-cycle
        for (int i = 0; i < 7; i++) fwd(2);
        wait_cycles(4);
        check("pre_reset_count", int'(count), 7);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst_count", int'(count), 0);
        check("async_rst_step", int'(step), 0);
        check("async_rst_err_flag", int'(err_flag), 0);
        @(negedge clk);
        model_reset();
        rst = 1'b1;
        wait_cycles(5);
        fwd(4);
        wait_cycles(2);
        check("post_reset_fwd_count", int'(count), 1);

        // clr coincident with a forward transition reaching decode
        raw_set(seq[(m_idx + 1) % 4]);
        wait_cycles(2);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        m_pos  = 0;
        m_flag = 1'b0;
        check("clr_coincident_count", int'(count), 0);
        wait_cycles(3);
        fwd(4);
        wait_cycles(2);
        check("no_replay_count", int'(count), 1);

        // Randomized walk
        for (int i = 0; i < 200; i++) begin
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
                do_clr();
                check("rand_clr_count", int'(count), 0);
            end else begin
                if (r <= 2)      v = seq[(m_idx + 2) % 4];
                else if (r == 3) v = seq[m_idx];
                else if (r < 12) v = seq[(m_idx + 1) % 4];
                else             v = seq[(m_idx + 3) % 4];
                set_ab(v);
                wait_cycles(int'($urandom_range(1, 4)));
            end
        end

        wait_cycles(6);
        check("final_count", int'(count), m_pos);
        check("final_dir", int'(dir), int'(m_dir));
        check("final_err_flag", int'(err_flag), int'(m_flag));
        check("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
